// File: rtl/stream_mux_rr_if.sv
// -----------------------------------------------------------------------------
// stream_mux_rr_if
//   Bundle of the handshake and data signals around stream_mux_rr: the N
//   producer streams, the single consumer stream and the selection controls.
//
//   Signals
//     mode       0 = fixed select via sel, 1 = round-robin arbitration
//     sel        channel index used when mode = 0
//     in_valid   per-channel valid, bit i belongs to channel i
//     in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//     in_ready   per-channel accept, one-hot or zero
//     out_valid  output register holds a beat
//     out_data   registered data of the held beat
//     out_chan   channel index that produced out_data
//     out_ready  consumer accepts the held beat
//
//   Modports
//     slave   : the multiplexer itself
//     master  : the environment (producers + consumer + selection control)
// -----------------------------------------------------------------------------
interface stream_mux_rr_if #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SEL_W = 2
);

  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_chan;
  logic               out_ready;

  modport slave (
    input  mode,
    input  sel,
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_chan,
    input  out_ready
  );

  modport master (
    output mode,
    output sel,
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_chan,
    output out_ready
  );

endinterface

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//   N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes and a
//   registered output stage. The source channel is chosen either by a fixed
//   select (mode = 0) or by round-robin arbitration (mode = 1) starting after
//   the most recently served channel.
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      asynchronous, active-low reset
//     bus        stream_mux_rr_if.slave (mode, sel, in_valid, in_data,
//                in_ready, out_valid, out_data, out_chan, out_ready)
//     grant_cnt  [8*N-1:0] per-channel saturating accept counters
//                (only when STREAM_MUX_GRANT_CNT_EN is defined)
//
//   Build option
//     STREAM_MUX_GRANT_CNT_EN : adds grant_cnt, one 8-bit counter per channel
//                               counting accepts, saturating at 255.
//
//   Timing
//     One cycle from accept to out_valid; one beat per cycle while out_ready
//     is high. in_ready is combinational from in_valid, sel, mode, out_ready.
// -----------------------------------------------------------------------------
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_mux_rr_if.slave      bus
`ifdef STREAM_MUX_GRANT_CNT_EN
  ,
  output logic [8*N-1:0]      grant_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;
  logic [SEL_W-1:0] last_q,      last_d;

  // ---------------------------------------------------------------------------
  // Grant logic
  // ---------------------------------------------------------------------------
  logic             load;
  logic             grant_ok;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] rr_idx;
  logic             accept;

  // The output register can take a beat when it is empty or being drained.
  assign load = bus.out_ready | ~out_valid_q;

  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    if (!bus.mode) begin
      // sel can exceed N-1 when N is not a power of two: no grant then.
      if (int'(bus.sel) < N) begin
        if (bus.in_valid[bus.sel]) begin
          grant_ok  = 1'b1;
          grant_idx = bus.sel;
        end
      end
    end else begin
      // Scan last+1, last+2, ... ending at last itself; first valid wins.
      for (int unsigned k = 1; k <= N; k++) begin
        rr_idx = SEL_W'((32'(last_q) + k) % N);
        if (!grant_ok && bus.in_valid[rr_idx]) begin
          grant_ok  = 1'b1;
          grant_idx = rr_idx;
        end
      end
    end
  end

  // A grant always refers to a valid channel, so load & grant is an accept.
  assign accept = load & grant_ok;

  always_comb begin
    bus.in_ready = '0;
    if (accept) begin
      bus.in_ready[grant_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register / last-grant pointer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    last_d      = last_q;
    if (load) begin
      if (grant_ok) begin
        out_valid_d = 1'b1;
        out_data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_chan_d  = grant_idx;
        last_d      = grant_idx;
      end else begin
        // Drained with nothing to replace it: data/chan keep their old values.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      // Pointing at N-1 puts channel 0 first in round-robin order.
      last_q      <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

`ifdef STREAM_MUX_GRANT_CNT_EN
  // ---------------------------------------------------------------------------
  // Per-channel saturating accept counters
  // ---------------------------------------------------------------------------
  logic [7:0] cnt_q [N];

  for (genvar i = 0; i < N; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[i] <= '0;
      end else if (accept && (grant_idx == SEL_W'(i)) && (cnt_q[i] != '1)) begin
        cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
    assign grant_cnt[i*8 +: 8] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
//   Self-checking bench for stream_mux_rr (N=4, WIDTH=4). A cycle model of the
//   arbiter predicts in_ready and pushes each accepted beat onto a scoreboard
//   queue; held output beats are compared against the queue head and popped
//   when the consumer takes them. Directed scenarios add fixed expectations.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk;
  logic rst_n;

  stream_mux_rr_if #(.WIDTH(W), .N(N), .SEL_W(SW)) bus ();

`ifdef STREAM_MUX_GRANT_CNT_EN
  logic [8*N-1:0] grant_cnt;
`endif

  stream_mux_rr #(.WIDTH(W), .N(N), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef STREAM_MUX_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus state
  logic          t_mode;
  logic [SW-1:0] t_sel;
  logic          t_ordy;
  logic          v [N];
  logic [W-1:0]  d [N];

  // Model state
  int            m_last;
  logic          m_ov;
  logic [SW+W-1:0] sb [$];
  logic          acc;
  int            acc_chan;
`ifdef STREAM_MUX_GRANT_CNT_EN
  int            m_cnt [N];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    bus.mode      = t_mode;
    bus.sel       = t_sel;
    bus.out_ready = t_ordy;
    for (int i = 0; i < N; i++) begin
      bus.in_valid[i]        = v[i];
      bus.in_data[i*W +: W]  = d[i];
    end
  endtask

  // Expected grant: rotate the valid vector so the channel after m_last is
  // bit 0, then pick the lowest set bit.
  task automatic model_grant(output logic ok, output int g);
    logic [N-1:0]   vv;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    ok = 1'b0;
    g  = 0;
    for (int i = 0; i < N; i++) vv[i] = v[i];
    if (!t_mode) begin
      if (int'(t_sel) < N && vv[t_sel]) begin
        ok = 1'b1;
        g  = int'(t_sel);
      end
    end else begin
      dbl = {vv, vv};
      rot = N'(dbl >> (m_last + 1));
      for (int j = 0; j < N; j++) begin
        if (!ok && rot[j]) begin
          ok = 1'b1;
          g  = (m_last + 1 + j) % N;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_ov   = 1'b0;
    sb.delete();
`ifdef STREAM_MUX_GRANT_CNT_EN
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step();
    logic         ok;
    int           g;
    logic         load;
    logic [N-1:0] exp_ready;
`ifdef STREAM_MUX_GRANT_CNT_EN
    logic [8*N-1:0] exp_cnt;
`endif
    drive_inputs();
    #1;
    model_grant(ok, g);
    load      = t_ordy | ~m_ov;
    exp_ready = (load && ok) ? N'(1 << g) : '0;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(0), 32'(1));
      end else begin
        check("out_data", 32'(bus.out_data), 32'(sb[0][W-1:0]));
        check("out_chan", 32'(bus.out_chan), 32'(sb[0][SW+W-1:W]));
        if (t_ordy) void'(sb.pop_front());
      end
    end
`ifdef STREAM_MUX_GRANT_CNT_EN
    for (int i = 0; i < N; i++) exp_cnt[i*8 +: 8] = 8'(m_cnt[i]);
    check("grant_cnt", 32'(grant_cnt), 32'(exp_cnt));
`endif
    acc      = 1'b0;
    acc_chan = 0;
    if (load) begin
      if (ok) begin
        sb.push_back({SW'(g), d[g]});
        m_ov     = 1'b1;
        m_last   = g;
        acc      = 1'b1;
        acc_chan = g;
`ifdef STREAM_MUX_GRANT_CNT_EN
        if (m_cnt[g] < 255) m_cnt[g]++;
`endif
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      d[i] = '0;
    end
    t_mode = 1'b0;
    t_sel  = '0;
    t_ordy = 1'b1;
    drive_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_data",  32'(bus.out_data),  32'(0));
    check("rst_out_chan",  32'(bus.out_chan),  32'(0));
`ifdef STREAM_MUX_GRANT_CNT_EN
    check("rst_grant_cnt", 32'(grant_cnt), 32'(0));
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_chan_seq [5] = '{0, 1, 2, 3, 0};
  int exp_data_seq [5] = '{1, 2, 3, 4, 1};

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);

    // Fixed select, single valid channel
    do_reset();
    t_mode = 1'b0; t_sel = 2'd2; v[2] = 1'b1; d[2] = 4'hA; t_ordy = 1'b1;
    drive_inputs();
    #1;
    check("fix_in_ready", 32'(bus.in_ready), 32'(4'b0100));
    step();
    check("fix_out_valid", 32'(bus.out_valid), 32'(1));
    check("fix_out_data",  32'(bus.out_data),  32'(4'hA));
    check("fix_out_chan",  32'(bus.out_chan),  32'(2));
    v[2] = 1'b0;
    step();

    // Round-robin over four held channels
    do_reset();
    t_mode = 1'b1;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1;
      d[i] = W'(i + 1);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr4_chan", 32'(bus.out_chan), 32'(exp_chan_seq[k]));
      check("rr4_data", 32'(bus.out_data), 32'(exp_data_seq[k]));
    end
    clear_inputs();
    step();

    // Round-robin with only channels 1 and 3
    do_reset();
    t_mode = 1'b1;
    v[1] = 1'b1; d[1] = 4'h9;
    v[3] = 1'b1; d[3] = 4'hC;
    for (int k = 0; k < 4; k++) begin
      drive_inputs();
      #1;
      check("rr2_no_0_2", 32'(bus.in_ready & 4'b0101), 32'(0));
      step();
      check("rr2_chan", 32'(bus.out_chan), 32'((k % 2 == 0) ? 1 : 3));
    end
    clear_inputs();
    step();

    // Backpressure
    do_reset();
    t_mode = 1'b0; t_sel = 2'd0; v[0] = 1'b1; d[0] = 4'h5; t_ordy = 1'b1;
    step();
    d[0] = 4'h6; t_ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_in_ready", 32'(bus.in_ready), 32'(0));
      check("bp_out_data", 32'(bus.out_data), 32'(4'h5));
    end
    t_ordy = 1'b1;
    step();
    check("bp_new_data", 32'(bus.out_data), 32'(4'h6));
    v[0] = 1'b0;
    step();
    check("bp_drained", 32'(bus.out_valid), 32'(0));
    check("bp_sb_empty", 32'(sb.size()), 32'(0));

    // Fixed select on an idle channel, then switch to round-robin
    t_mode = 1'b0; t_sel = 2'd0; v[0] = 1'b1; d[0] = 4'h7;
    step();
    t_sel = 2'd1; d[0] = 4'h8;
    step();
    check("nogrant_out_valid", 32'(bus.out_valid), 32'(0));
    t_mode = 1'b1;
    drive_inputs();
    #1;
    check("switch_in_ready", 32'(bus.in_ready), 32'(4'b0001));
    step();
    check("switch_chan", 32'(bus.out_chan), 32'(0));
    check("switch_data", 32'(bus.out_data), 32'(4'h8));
    v[0] = 1'b0;

    // Asynchronous reset while a beat is held
    t_mode = 1'b0; t_sel = 2'd1; v[1] = 1'b1; d[1] = 4'h3; t_ordy = 1'b0;
    step();
    check("ar_pre_valid", 32'(bus.out_valid), 32'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(bus.out_valid), 32'(0));
    check("ar_out_data",  32'(bus.out_data),  32'(0));
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with producers holding until accepted
    for (int c = 0; c < 400; c++) begin
      t_mode = 1'($urandom_range(0, 1));
      t_sel  = SW'($urandom_range(0, N - 1));
      t_ordy = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          d[i] = W'($urandom);
        end
      end
      step();
      if (acc) begin
        if ($urandom_range(0, 1) == 1) d[acc_chan] = W'($urandom);
        else v[acc_chan] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    t_ordy = 1'b1;
    step();
    step();
    check("final_sb_empty", 32'(sb.size()), 32'(0));

`ifdef STREAM_MUX_GRANT_CNT_EN
    // Counter saturation on channel 2
    do_reset();
    t_mode = 1'b0; t_sel = 2'd2; v[2] = 1'b1; d[2] = 4'h2; t_ordy = 1'b1;
    for (int k = 0; k < 300; k++) step();
    check("cnt_sat_ch2", 32'(grant_cnt[23:16]), 32'(255));
    check("cnt_others",  32'({grant_cnt[31:24], grant_cnt[15:0]}), 32'(0));
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every port.
- Successor to the team's combinational 4x1 4-bit mux; supports any channel count and width.
- Adds a registered output stage and two selection modes: fixed select, or round-robin arbitration.
- Sits between several producer streams and one consumer, e.g. a shared display or bus interface.

Parameters:
- WIDTH, 4, data bits per channel.
- N, 4, number of input channels; N >= 2.
- SEL_W, 2, select/channel-index width; must equal clog2(N).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = fixed select via sel, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode = 0.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_chan  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, internal last-grant pointer last=N-1. This makes channel 0 first in round-robin order.
- load = out_ready | ~out_valid. The output register may take a new beat this cycle only when load = 1.
- Grant g is combinational:
  - mode=0: g = sel if sel < N and in_valid[sel] = 1; otherwise no grant.
  - mode=1: g = first i with in_valid[i] = 1, scanning (last+1) mod N, (last+2) mod N, … up to last. Wraps N-1 -> 0. No grant if in_valid = 0.
- in_ready[i] = load & grant_exists & (g == i). At most one bit is set. in_ready may depend combinationally on in_valid, sel, mode and out_ready.
- Accept (in_valid[g] & in_ready[g]) at a clock edge sets out_valid=1, out_data=in_data[g], out_chan=g, last=g.
- load=1 with no grant: out_valid<=0. out_data and out_chan hold their previous values.
- load=0: all output registers and last hold. This is the stall.
- Latency: 1 cycle from accept to out_valid. Full throughput is 1 beat/cycle while out_ready=1.
- Producers hold in_valid and in_data stable until accepted. The block never drops or duplicates a beat.
- last is updated only on accept. Mode-0 grants also update last, so a switch to mode 1 continues round-robin from the channel after the last one served.
- sel >= N (possible when N is not a power of 2): no grant, in_ready = 0.
- Mode or sel change takes effect on the same cycle's grant. It never affects a beat already in the output register.
- Asynchronous reset mid-transfer: the held beat is discarded and out_valid drops immediately.

Optional Feature:
- Macro: STREAM_MUX_GRANT_CNT_EN.
- Defined: adds output grant_cnt [8*N-1:0], one 8-bit counter per channel.
  - Counter i increments on each accept from channel i and saturates at 255.
  - Counters clear to 0 on reset.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, mode=0, sel=2, in_valid=4'b0100, in_data ch2=4'hA, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=4'hA, out_chan=2.
- mode=1, in_valid=4'b1111 held, data ch0..3 = 1,2,3,4, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, matching data 1,2,3,4,1.
- mode=1, only channels 1 and 3 valid, last=3 -> grants 1,3,1,3. Channels 0 and 2 never show in_ready.
- Backpressure: out_valid=1 with out_data=4'h5, out_ready=0 for 3 cycles, ch0 valid with 4'h6 -> in_ready=0 and out_data stays 4'h5. After out_ready=1: 4'h6 appears next cycle, with no loss or duplicate.
- mode=0, sel=1, in_valid=4'b0001 -> no grant; out_valid falls to 0 after the pending beat drains. Switch to mode=1 -> ch0 is granted.
- rst_n pulsed low between clock edges while out_valid=1 -> out_valid=0 immediately. With STREAM_MUX_GRANT_CNT_EN defined: after 300 ch2 accepts, grant_cnt for ch2 = 255, and reset clears all counters.
